// File: rtl/isp_stream_gen.sv
// ISP pixel-stream source: turns a valid/ready pixel feed into vsync/href/clken raster frames.
// Define ISP_STREAM_GEN_PATTERN_EN to build the internal colour-bar generator.
module isp_stream_gen #(
  parameter int DW      = 24,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int VS_LEN  = 4,
  parameter int V_BLANK = 20,
  parameter int H_BLANK = 160
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pattern_sel,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          post_img_vsync,
  output logic          post_img_href,
  output logic          post_img_clken,
  output logic [DW-1:0] post_img_data,
  output logic          frame_done,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [2:0] {IDLE, VSYNC, VBLANK, LINE, HBLANK} state_t;

  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BMAX = (VS_LEN > V_BLANK) ? ((VS_LEN > H_BLANK) ? VS_LEN : H_BLANK)
                                           : ((V_BLANK > H_BLANK) ? V_BLANK : H_BLANK);
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [BW-1:0] VS_LAST  = BW'(VS_LEN - 1);
  localparam logic [BW-1:0] VB_LAST  = BW'(V_BLANK - 1);
  localparam logic [BW-1:0] HB_LAST  = BW'(H_BLANK - 1);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] cnt;
  logic          pattern_mode;
  logic          xfer;
  logic          line_end;
  logic          vs_entry;
  logic [DW-1:0] pix;

`ifdef ISP_STREAM_GEN_PATTERN_EN
  logic [2:0] bar;

  // The mode is latched at frame start so a frame is never half bars, half upstream.
  always_ff @(posedge clk) begin
    if (rst)           pattern_mode <= 1'b0;
    else if (vs_entry) pattern_mode <= pattern_sel;
  end

  always_comb begin
    bar = 3'((int'(col) * 8) / IMG_W);
    pix = pattern_mode ? DW'({{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}}) : s_data;
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pattern_mode       = 1'b0;
  assign pix                = s_data;
`endif

  // Ready depends only on registered state (and reset), never on s_valid.
  assign s_ready = ~rst & (state == LINE) & ~pattern_mode;

  // NOTE: every signal here is assigned on every evaluation, so no latch is inferred.
  always_comb begin
    xfer     = (state == LINE) & (pattern_mode | (s_valid & s_ready));
    line_end = xfer & (col == COL_LAST);
    vs_entry = enable & ((state == IDLE) |
                         ((state == HBLANK) & (cnt == HB_LAST) & (row == '0)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      cnt            <= '0;
      post_img_vsync <= 1'b0;
      post_img_href  <= 1'b0;
      post_img_clken <= 1'b0;
      post_img_data  <= '0;
      frame_done     <= 1'b0;
      stall_cnt      <= '0;
    end else begin
      post_img_vsync <= (state == VSYNC);
      post_img_href  <= (state == LINE);
      post_img_clken <= xfer;
      frame_done     <= line_end & (row == ROW_LAST);
      if (xfer) post_img_data <= pix;

      if (vs_entry)
        stall_cnt <= '0;
      else if ((state == LINE) && !xfer && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;

      if (xfer) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (vs_entry) state <= VSYNC;
        end
        VSYNC: begin
          if (cnt == VS_LAST) begin
            cnt   <= '0;
            state <= VBLANK;
          end else cnt <= cnt + 1'b1;
        end
        VBLANK: begin
          if (cnt == VB_LAST) begin
            cnt   <= '0;
            state <= LINE;
          end else cnt <= cnt + 1'b1;
        end
        LINE: begin
          if (line_end) state <= HBLANK;
        end
        HBLANK: begin
          if (cnt == HB_LAST) begin
            cnt <= '0;
            // row has wrapped to 0 only after the last line of the frame
            if (row != '0)     state <= LINE;
            else if (vs_entry) state <= VSYNC;
            else               state <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
